// File: rtl/arm_pkg.sv
// ---------------------------------------------------------------------------
// arm_pkg
// Shared constants and types for the ARM pipeline front end.
//   ADDR_W / INSTR_W : address and instruction word widths
//   RESET_PC         : default PC after reset (word-aligned)
//   fetch_entry_t    : one prefetch queue entry {instr, pc_plus4}
//   word_align()     : clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package arm_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc_plus4;
  } fetch_entry_t;

  // Instruction addresses are always word-aligned; the low two bits of any
  // externally supplied address are meaningless and forced to zero.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_if
// Bundles the fetch unit's external buses:
//   imem_address / imem_instruction : instruction memory request/return
//   branch_taken / branch_target    : redirect from execute
//   out_valid / out_ready /
//   out_instruction / out_pc        : valid/ready handshake to decode
// Modports:
//   master : the fetch unit itself
//   slave  : the environment (memory, execute, decode)
// ---------------------------------------------------------------------------
interface instruction_fetch_unit_if;
  import arm_pkg::*;

  logic [ADDR_W-1:0]  imem_address;
  logic [INSTR_W-1:0] imem_instruction;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instruction;
  logic [ADDR_W-1:0]  out_pc;

  modport master (
    output imem_address,
    input  imem_instruction,
    input  branch_taken,
    input  branch_target,
    output out_valid,
    input  out_ready,
    output out_instruction,
    output out_pc
  );

  modport slave (
    input  imem_address,
    output imem_instruction,
    output branch_taken,
    output branch_target,
    input  out_valid,
    output out_ready,
    input  out_instruction,
    input  out_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Synchronous FIFO of fetch_entry_t with a registered head entry.
//   clk, rst     : clock, synchronous active-high reset
//   push_i       : enqueue push_data_i (ignored when full without a pop)
//   pop_i        : consume the head entry (ignored when empty)
//   flush_i      : discard all entries; wins over push_i
//   push_data_i  : entry to enqueue
//   head_o       : current head entry (register)
//   valid_o      : head entry is valid (register)
//   full_o       : occupancy equals DEPTH
//   empty_o      : no valid entry
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module fetch_queue
  import arm_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t push_data_i,
  output fetch_entry_t head_o,
  output logic         valid_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     head_q, head_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q;
  logic             do_pop;
  logic             do_push;

  assign full_o  = (cnt_q == CNT_FULL);
  assign empty_o = ~valid_q;
  assign valid_o = valid_q;
  assign head_o  = head_q;

  // A pop frees a slot in the same cycle, so a full queue still accepts a push.
  assign do_pop  = pop_i & valid_q & ~flush_i;
  assign do_push = push_i & ~flush_i & (~full_o | do_pop);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    head_d   = head_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      head_d   = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase

      // The head register must show the entry that sits at the read pointer
      // after this edge: the next stored entry, the one being pushed into an
      // empty slot, or nothing.
      if (do_pop) begin
        if (cnt_q > CNT_ONE) head_d = mem_q[rd_ptr_d];
        else if (do_push)    head_d = push_data_i;
        else                 head_d = '0;
      end else if (do_push && !valid_q) begin
        head_d = push_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
      // NOTE: the storage array is cleared on reset as well, so no stale
      // instruction from before reset can ever reach the head register.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      valid_q  <= (cnt_d != '0);
      head_q   <= head_d;
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// Fetch stage: holds the PC, requests one word per cycle from instruction
// memory, buffers {instruction, PC+4} in a prefetch queue and hands the head
// entry to decode. A taken branch flushes the queue and redirects the PC.
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : instruction_fetch_unit_if.master
//          imem_address (PC register), imem_instruction (same-cycle return),
//          branch_taken / branch_target, out_valid / out_ready,
//          out_instruction / out_pc (head entry, PC+4 of that instruction)
// Parameters:
//   QUEUE_DEPTH : prefetch entries, power of two, >= 2
//   RESET_PC    : PC loaded on reset, word-aligned
// ---------------------------------------------------------------------------
module instruction_fetch_unit
  import arm_pkg::*;
#(
  parameter int                        QUEUE_DEPTH = 2,
  parameter logic [arm_pkg::ADDR_W-1:0] RESET_PC    = arm_pkg::RESET_PC
) (
  input  logic                     clk,
  input  logic                     rst,
  instruction_fetch_unit_if.master bus
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              q_full;
  logic              q_empty;
  logic              q_valid;
  logic              deq;
  logic              fetch;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  // A handshake completes whenever the head is valid and decode is ready,
  // even in a branch cycle; the flush then simply discards the rest.
  assign deq   = bus.out_ready & ~q_empty;
  assign fetch = ~bus.branch_taken & (~q_full | deq);

  assign push_entry.instr    = bus.imem_instruction;
  assign push_entry.pc_plus4 = pc_q + ADDR_W'(4);

  always_comb begin
    pc_d = pc_q;
    if (bus.branch_taken) pc_d = word_align(bus.branch_target);
    else if (fetch)       pc_d = pc_q + ADDR_W'(4);
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fetch),
    .pop_i       (deq),
    .flush_i     (bus.branch_taken),
    .push_data_i (push_entry),
    .head_o      (head),
    .valid_o     (q_valid),
    .full_o      (q_full),
    .empty_o     (q_empty)
  );

  assign bus.imem_address    = pc_q;
  assign bus.out_valid       = q_valid;
  assign bus.out_instruction = head.instr;
  assign bus.out_pc          = head.pc_plus4;

endmodule
